// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence stepper.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } seq_state_t;

  localparam int SEQ_IDX_W = 5;

  // Modulo-2^SEQ_IDX_W neighbour of idx; down selects -1, otherwise +1.
  function automatic logic [SEQ_IDX_W-1:0] seq_next(input logic [SEQ_IDX_W-1:0] idx,
                                                     input logic down);
    logic [SEQ_IDX_W-1:0] res;
    if (down) begin
      res = idx - {{(SEQ_IDX_W-1){1'b0}}, 1'b1};
    end else begin
      res = idx + {{(SEQ_IDX_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_prescaler.sv
// Rate prescaler for seq_stepper: counts 0..DIV-1 while enabled, flags the
// terminal count with a wrap pulse, and holds its value when disabled.
module seq_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  assign wrap = en && (cnt_r == LAST);

  // Counter: clear has priority; disabled keeps the count so a pause can resume mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (wrap) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/seq_stepper.sv
// Run/pause/stop sequencer producing the 5-bit index for the LED pattern decoder.
// Optional SEQ_STEPPER_PINGPONG_EN: bounce between 0 and 31, ignoring dir.
module seq_stepper
  import seq_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int IDX_W = SEQ_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  output logic [IDX_W-1:0] seqidx,
  output logic             tick,
  output logic             running
);

  seq_state_t state_r;
  seq_state_t state_nx_s;
  logic       pre_en_s;
  logic       pre_clr_s;
  logic       wrap_s;
  logic       adv_s;
  logic       down_s;
  logic       stop_clr_s;
  logic [IDX_W-1:0] next_idx_s;

`ifdef SEQ_STEPPER_PINGPONG_EN
  logic pp_dir_r;
`endif

  seq_prescaler #(.DIV(DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en_s),
    .clr  (pre_clr_s),
    .wrap (wrap_s)
  );

  // Next-state, advance request and prescaler control; stop beats start.
  always_comb begin
    state_nx_s = state_r;
    adv_s      = 1'b0;
    stop_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        adv_s = step;
        if (stop) begin
          state_nx_s = ST_IDLE;
        end else if (start) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        adv_s = wrap_s;
        if (stop) begin
          state_nx_s = ST_PAUSE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_nx_s = ST_IDLE;
          stop_clr_s = 1'b1;
        end else if (start) begin
          state_nx_s = ST_RUN;
          adv_s      = step;
        end else begin
          state_nx_s = ST_PAUSE;
          adv_s      = step;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        adv_s      = 1'b0;
      end
    endcase
    pre_en_s  = (state_r == ST_RUN);
    pre_clr_s = (state_r == ST_IDLE) || stop_clr_s;
`ifdef SEQ_STEPPER_PINGPONG_EN
    down_s = pp_dir_r;
`else
    down_s = dir;
`endif
    next_idx_s = seq_next(seqidx, down_s);
  end

  // State, index and registered outputs; tick marks the first cycle of a new index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      seqidx  <= {IDX_W{1'b0}};
      tick    <= 1'b0;
      running <= 1'b0;
`ifdef SEQ_STEPPER_PINGPONG_EN
      pp_dir_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nx_s;
      running <= (state_nx_s == ST_RUN);
      tick    <= adv_s;
      if (stop_clr_s) begin
        seqidx <= {IDX_W{1'b0}};
      end else if (adv_s) begin
        seqidx <= next_idx_s;
      end else begin
        seqidx <= seqidx;
      end
`ifdef SEQ_STEPPER_PINGPONG_EN
      // Turn around on the advance that lands on either endpoint.
      if (stop_clr_s) begin
        pp_dir_r <= 1'b0;
      end else if (adv_s && ((next_idx_s == {IDX_W{1'b1}}) || (next_idx_s == {IDX_W{1'b0}}))) begin
        pp_dir_r <= ~pp_dir_r;
      end else begin
        pp_dir_r <= pp_dir_r;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_stepper.sv
// Directed bench for seq_stepper (DIV=3; DIV=1 ping-pong when SEQ_STEPPER_PINGPONG_EN).
module tb_seq_stepper;

`ifdef SEQ_STEPPER_PINGPONG_EN
  localparam int DIV_T = 1;
`else
  localparam int DIV_T = 3;
`endif

  typedef struct {
    logic       start;
    logic       stop;
    logic       step;
    logic       dir;
    logic [4:0] idx;
    logic       tick;
    logic       run;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic       dir = 1'b0;
  logic [4:0] seqidx;
  logic       tick;
  logic       running;

  int n_chk = 0;
  int n_fail = 0;
  vec_t vq[$];

  seq_stepper #(.DIV(DIV_T), .IDX_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .dir     (dir),
    .seqidx  (seqidx),
    .tick    (tick),
    .running (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input int i, input int tk, input int r);
    chk({name, " seqidx"}, int'(seqidx), i);
    chk({name, " tick"}, int'(tick), tk);
    chk({name, " running"}, int'(running), r);
  endtask

  // Drive inputs for one cycle; outputs are then read 1ns after the edge.
  task automatic cyc(input logic s, input logic p, input logic t, input logic d);
    start = s; stop = p; step = t; dir = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, p, t, d, input logic [4:0] i, input logic tk, r);
    vec_t v;
    v.start = s; v.stop = p; v.step = t; v.dir = d;
    v.idx = i; v.tick = tk; v.run = r;
    vq.push_back(v);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk3("reset", 0, 0, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk3("post reset idle", 0, 0, 0);

`ifdef SEQ_STEPPER_PINGPONG_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk3("pp start", 0, 0, 1);
    for (int k = 1; k <= 70; k++) begin
      int t;
      cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      t = k % 62;
      chk($sformatf("pp idx k=%0d", k), int'(seqidx), (t <= 31) ? t : 62 - t);
      chk($sformatf("pp tick k=%0d", k), int'(tick), 1);
    end
`else
    // test 1: free run up through the wrap
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk3("t1 start", 0, 0, 1);
    for (int k = 1; k <= 32; k++) begin
      for (int c = 1; c <= 3; c++) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk($sformatf("t1 idx k=%0d c=%0d", k, c), int'(seqidx), (c == 3) ? (k % 32) : (k - 1));
        chk($sformatf("t1 tick k=%0d c=%0d", k, c), int'(tick), (c == 3) ? 1 : 0);
      end
    end
    chk("t1 running", int'(running), 1);

    // test 2: pause at 5 mid-period, resume, stop on a wrap cycle, then stop to idle
    repeat (15) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk3("t2 at 5", 5, 1, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("t2 paused", 5, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk3("t2 hold", 5, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk3("t2 resume", 5, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk3("t2 first adv", 6, 1, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk3("t2 gap a", 6, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk3("t2 gap b", 6, 0, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("t2 adv+stop", 7, 1, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("t2 stop idle", 0, 0, 0);

    // tests 3/4 as a vector table, starting in IDLE at 0
    add(0, 0, 1, 1, 5'd31, 1, 0);
    add(0, 0, 0, 1, 5'd31, 0, 0);
    add(0, 0, 1, 1, 5'd30, 1, 0);
    add(0, 0, 0, 1, 5'd30, 0, 0);
    add(1, 0, 0, 1, 5'd30, 0, 1);
    add(0, 0, 1, 1, 5'd30, 0, 1);
    add(0, 0, 1, 1, 5'd30, 0, 1);
    add(0, 0, 1, 1, 5'd29, 1, 1);
    add(0, 1, 0, 1, 5'd29, 0, 0);
    add(0, 0, 1, 0, 5'd30, 1, 0);
    add(0, 0, 0, 0, 5'd30, 0, 0);
    add(1, 0, 0, 0, 5'd30, 0, 1);
    add(0, 0, 0, 0, 5'd30, 0, 1);
    add(0, 0, 0, 0, 5'd31, 1, 1);
    add(0, 0, 0, 0, 5'd31, 0, 1);
    add(0, 0, 0, 0, 5'd31, 0, 1);
    add(0, 0, 0, 0, 5'd0,  1, 1);
    add(0, 1, 0, 0, 5'd0,  0, 0);
    add(0, 1, 0, 0, 5'd0,  0, 0);
    add(1, 1, 0, 0, 5'd0,  0, 0);
    add(0, 0, 0, 0, 5'd0,  0, 0);
    add(0, 0, 0, 0, 5'd0,  0, 0);
    add(0, 0, 0, 0, 5'd0,  0, 0);
    add(0, 0, 0, 0, 5'd0,  0, 0);
    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].start, vq[i].stop, vq[i].step, vq[i].dir);
      chk3($sformatf("vec %0d", i), int'(vq[i].idx), int'(vq[i].tick), int'(vq[i].run));
    end

    // test 5: async reset mid-run at seqidx=17, prescaler=1
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (52) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk3("t5 before rst", 17, 0, 1);
    rst = 1'b1;
    #1;
    chk3("t5 async rst", 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk3("t5 after rst idle", 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
